// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the MEM-stage data cache: controller states and geometry defaults.
package dcache_responder_pkg;

  localparam int ADDR_BITS       = 16;
  localparam int DEF_INDEX_BITS  = 2;
  localparam int DEF_OFFSET_BITS = 2;
  localparam int TAG_BITS        = ADDR_BITS - DEF_INDEX_BITS - DEF_OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  function automatic int tag_bits(input int index_bits, input int offset_bits);
    return ADDR_BITS - index_bits - offset_bits;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous read, one synchronous write port.
module dcache_array
  import dcache_responder_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int TAG_W       = TAG_BITS
) (
  input  logic                   Clk,
  input  logic                   Reset_N,
  input  logic [INDEX_BITS-1:0]  rd_index_i,
  input  logic [OFFSET_BITS-1:0] rd_offset_i,
  output logic                   rd_valid_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic [15:0]            rd_data_o,
  input  logic                   we_i,
  input  logic                   tag_we_i,
  input  logic [INDEX_BITS-1:0]  wr_index_i,
  input  logic [OFFSET_BITS-1:0] wr_offset_i,
  input  logic [15:0]            wr_data_i,
  input  logic [TAG_W-1:0]       wr_tag_i
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES][WORDS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) begin
      valid_q <= '0;
    end else if (we_i && tag_we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge Clk) begin
    if (we_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
      if (tag_we_i) begin
        tag_q[wr_index_i] <= wr_tag_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache serving the MEM-stage data port;
// fills lines word-by-word over a req/ack memory handshake and freezes the pipeline meanwhile.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        d_readM,
  input  logic        d_writeM,
  input  logic [15:0] d_address,
  inout  wire  [15:0] d_data,
  output logic [1:0]  cacheStall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int TAG_W  = tag_bits(INDEX_BITS, OFFSET_BITS);
  localparam int LINE_W = INDEX_BITS + OFFSET_BITS;

  state_e                  state_q, state_d;
  logic [15-OFFSET_BITS:0] line_q, line_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
  logic [15:0]             wr_addr_q, wr_addr_d;
  logic [15:0]             wr_data_q, wr_data_d;
  logic                    wr_done_q, wr_done_d;
  logic                    fill_done_q, fill_done_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;

  logic [15:0]             rd_addr;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [15:0]             rd_data;
  logic                    hit, wr_pending, rd_req, rd_hit, rd_miss, drive_rd;
  logic                    arr_we, arr_tag_we;
  logic [INDEX_BITS-1:0]   arr_wr_index;
  logic [OFFSET_BITS-1:0]  arr_wr_offset;
  logic [15:0]             arr_wr_data;

  // While a write is in flight the lookup follows the latched address for the write-hit update.
  assign rd_addr = (state_q == ST_WRITE) ? wr_addr_q : d_address;
  assign hit     = rd_valid && (rd_tag == rd_addr[15:LINE_W]);

  // The done flags mark the completion cycle so a held request is not serviced twice.
  assign wr_pending = d_writeM && !wr_done_q;
  assign rd_req     = d_readM && !d_writeM;
  assign rd_hit     = rd_req && hit;
  assign rd_miss    = rd_req && !hit && !fill_done_q;
  assign drive_rd   = (state_q == ST_IDLE) && rd_hit && !Reset_N;

  assign d_data   = drive_rd ? rd_data : 16'hzzzz;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .rd_index_i (rd_addr[LINE_W-1:OFFSET_BITS]),
    .rd_offset_i(rd_addr[OFFSET_BITS-1:0]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (arr_we),
    .tag_we_i   (arr_tag_we),
    .wr_index_i (arr_wr_index),
    .wr_offset_i(arr_wr_offset),
    .wr_data_i  (arr_wr_data),
    .wr_tag_i   (line_q[15-OFFSET_BITS:INDEX_BITS])
  );

  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) begin
      line_q      <= '0;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_done_q   <= 1'b0;
      fill_done_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_done_q   <= wr_done_d;
      fill_done_q <= fill_done_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_done_d   = 1'b0;
    fill_done_d = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_pending) begin
          wr_addr_d = d_address;
          wr_data_d = d_data;
          state_d   = ST_WRITE;
        end else if (rd_miss) begin
          miss_cnt_d = miss_cnt_q + 16'd1;
          line_d     = d_address[15:OFFSET_BITS];
          cnt_d      = '0;
          state_d    = ST_FILL;
        end else if (rd_hit && !fill_done_q) begin
          hit_cnt_d = hit_cnt_q + 16'd1;
        end
      end
      ST_FILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            fill_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          wr_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cacheStall    = 2'b00;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    arr_we        = 1'b0;
    arr_tag_we    = 1'b0;
    arr_wr_index  = line_q[INDEX_BITS-1:0];
    arr_wr_offset = cnt_q;
    arr_wr_data   = mem_rdata;
    unique case (state_q)
      ST_IDLE: cacheStall[1] = wr_pending || rd_miss;
      ST_FILL: begin
        cacheStall[1] = 1'b1;
        mem_req       = 1'b1;
        mem_addr      = {line_q, cnt_q};
        arr_we        = mem_ack;
        arr_tag_we    = mem_ack && (&cnt_q);
      end
      ST_WRITE: begin
        // Write-through without allocation: only an already-resident line is updated.
        cacheStall[1] = 1'b1;
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = wr_addr_q;
        mem_wdata     = wr_data_q;
        arr_we        = mem_ack && hit;
        arr_wr_index  = wr_addr_q[LINE_W-1:OFFSET_BITS];
        arr_wr_offset = wr_addr_q[OFFSET_BITS-1:0];
        arr_wr_data   = wr_data_q;
      end
      default: cacheStall = 2'b00;
    endcase
    if (Reset_N) cacheStall = 2'b00;
  end

endmodule
